// File: rtl/hs_spi_avmm_arbiter.sv
// hs_spi_avmm_arbiter: N:1 burst-locked AVMM arbiter in front of hs_spi_master_avmm_m.
// Define HS_SPI_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module hs_spi_avmm_arbiter #(
  parameter int N         = 3,
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int MAX_BURST = 256,
  localparam int BW       = $clog2(MAX_BURST) + 1,
  localparam int OW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*AW-1:0] req_address,
  input  logic [N-1:0]    req_read,
  input  logic [N-1:0]    req_write,
  input  logic [N*DW-1:0] req_writedata,
  input  logic [N*BW-1:0] req_burstcount,
  output logic [N-1:0]    req_waitrequest,
  output logic [DW-1:0]   req_readdata,
  output logic [N-1:0]    req_readdatavalid,
  output logic [AW-1:0]   spi_address,
  output logic            spi_read,
  output logic            spi_write,
  output logic [DW-1:0]   spi_writedata,
  output logic [BW-1:0]   spi_burstcount,
  input  logic            spi_waitrequest,
  input  logic [DW-1:0]   spi_readdata,
  input  logic            spi_readdatavalid,
  input  logic            spi_idle,
  output logic [OW-1:0]   owner,
  output logic            busy
);

  typedef enum logic [2:0] {
    ARB,
    XFER_WR,
    XFER_RD_CMD,
    XFER_RD_DATA,
    RELEASE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] owner_d;
  logic [OW-1:0] win;
  logic [OW-1:0] idx;
  logic [BW-1:0] cnt_q;
  logic [BW-1:0] cnt_d;
  logic [BW-1:0] len_q;
  logic [BW-1:0] len_d;
  logic [BW-1:0] win_bc;
  logic [N-1:0]  pending;
  logic          found;
  logic          last;
  logic          xfer;
`ifndef HS_SPI_ARB_FIXED_PRIO_EN
  logic [OW-1:0] ptr_q;
  logic [OW-1:0] ptr_d;
`endif

  // Winner search: first pending index at/after the pointer, wrapping.
  always_comb begin
    pending = req_read | req_write;
    win     = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
`ifdef HS_SPI_ARB_FIXED_PRIO_EN
      idx = OW'(k);
`else
      idx = OW'((int'(ptr_q) + k) % N);
`endif
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_bc = req_burstcount[int'(win)*BW +: BW];

  assign spi_address    = req_address[int'(owner_q)*AW +: AW];
  assign spi_writedata  = req_writedata[int'(owner_q)*DW +: DW];
  assign spi_burstcount = req_burstcount[int'(owner_q)*BW +: BW];
  assign req_readdata   = spi_readdata;
  assign owner          = owner_q;
  assign busy           = (state_q != ARB);
  assign last           = (cnt_q == len_q - 1'b1);

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    cnt_d             = cnt_q;
    len_d             = len_q;
`ifndef HS_SPI_ARB_FIXED_PRIO_EN
    ptr_d             = ptr_q;
`endif
    spi_read          = 1'b0;
    spi_write         = 1'b0;
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    xfer = (state_q == XFER_WR) ||
           (state_q == XFER_RD_CMD) ||
           (state_q == XFER_RD_DATA);
    if (xfer) begin
      req_waitrequest[owner_q] = spi_waitrequest;
    end
    unique case (state_q)
      ARB: begin
        if (found) begin
          owner_d = win;
          cnt_d   = '0;
          len_d   = (win_bc == '0) ? BW'(1) : win_bc;
          state_d = req_write[win] ? XFER_WR : XFER_RD_CMD;
        end
      end
      XFER_WR: begin
        spi_write = req_write[owner_q];
        if (spi_write && !spi_waitrequest) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = RELEASE;
          end
        end
      end
      XFER_RD_CMD: begin
        spi_read = req_read[owner_q];
        if (spi_read && !spi_waitrequest) begin
          state_d = XFER_RD_DATA;
        end
      end
      XFER_RD_DATA: begin
        req_readdatavalid[owner_q] = spi_readdatavalid;
        if (spi_readdatavalid) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        // Hold the grant until the master reports idle, never sampled stale.
        if (spi_idle) begin
`ifndef HS_SPI_ARB_FIXED_PRIO_EN
          ptr_d = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
`endif
          cnt_d   = '0;
          state_d = ARB;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      owner_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

`ifndef HS_SPI_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_hs_spi_avmm_arbiter.sv
// tb_hs_spi_avmm_arbiter: scoreboard bench with a transaction-level
// arbitration model and a behavioural SPI-master stand-in.
module tb_hs_spi_avmm_arbiter;
  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 256;
  localparam int BW = $clog2(MB) + 1;
  localparam int OW = $clog2(N);

  logic            clk;
  logic            rst;
  logic [N*AW-1:0] req_address;
  logic [N-1:0]    req_read;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_writedata;
  logic [N*BW-1:0] req_burstcount;
  logic [N-1:0]    req_waitrequest;
  logic [DW-1:0]   req_readdata;
  logic [N-1:0]    req_readdatavalid;
  logic [AW-1:0]   spi_address;
  logic            spi_read;
  logic            spi_write;
  logic [DW-1:0]   spi_writedata;
  logic [BW-1:0]   spi_burstcount;
  logic            spi_waitrequest;
  logic [DW-1:0]   spi_readdata;
  logic            spi_readdatavalid;
  logic            spi_idle;
  logic [OW-1:0]   owner;
  logic            busy;

  hs_spi_avmm_arbiter #(
    .N(N), .AW(AW), .DW(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .req_address(req_address),
    .req_read(req_read),
    .req_write(req_write),
    .req_writedata(req_writedata),
    .req_burstcount(req_burstcount),
    .req_waitrequest(req_waitrequest),
    .req_readdata(req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .spi_address(spi_address),
    .spi_read(spi_read),
    .spi_write(spi_write),
    .spi_writedata(spi_writedata),
    .spi_burstcount(spi_burstcount),
    .spi_waitrequest(spi_waitrequest),
    .spi_readdata(spi_readdata),
    .spi_readdatavalid(spi_readdatavalid),
    .spi_idle(spi_idle),
    .owner(owner),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int            kind;
    int            who;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] bc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 0;
  int  ptr_m = 0;

  bit            r_wr[N];
  bit            r_rd[N];
  bit            r_late[N];
  logic [AW-1:0] r_addr[N];
  logic [BW-1:0] r_bc[N];
  bit            use_seq = 0;

  logic [AW-1:0] d_addr[N];
  logic [BW-1:0] d_bc[N];
  logic [DW-1:0] d_wdat[N][MB];
  int            d_wlen[N];
  int            d_wbeat[N];
  int            d_rlen[N];
  int            d_rgot[N];
  bit            d_wact[N];
  bit            d_ract[N];
  bit            d_rwait[N];
  bit            d_hold[N];

  bit            s_wopen = 0;
  int            s_wrem = 0;
  int            s_tail = 0;
  logic [DW-1:0] s_rdq[$];

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic int blen(logic [BW-1:0] b);
    return (b == '0) ? 1 : int'(b);
  endfunction

  function automatic logic [DW-1:0] rdat(logic [AW-1:0] a, int k);
    logic [21:0] kk;
    kk = 22'(k);
    return {a, kk} ^ 32'h5A3C_0000;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_address[i*AW +: AW]    = d_addr[i];
      req_burstcount[i*BW +: BW] = d_bc[i];
      req_write[i] = d_wact[i] && !d_hold[i];
      req_read[i]  = d_ract[i] && !d_rwait[i] && !d_hold[i];
      req_writedata[i*DW +: DW] =
        (d_wbeat[i] < MB) ? d_wdat[i][d_wbeat[i]] : '0;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      d_addr[i] = '0; d_bc[i] = '0;
      d_wlen[i] = 0; d_wbeat[i] = 0;
      d_rlen[i] = 0; d_rgot[i] = 0;
      d_wact[i] = 0; d_ract[i] = 0;
      d_rwait[i] = 0; d_hold[i] = 0;
      r_wr[i] = 0; r_rd[i] = 0; r_late[i] = 0;
      r_addr[i] = '0; r_bc[i] = '0;
    end
    s_wopen = 0; s_wrem = 0; s_tail = 0;
    s_rdq.delete();
    spi_readdatavalid = 1'b0;
    spi_readdata = '0;
    spi_waitrequest = 1'b0;
    spi_idle = 1'b1;
    apply();
  endtask

  // Transaction-level arbitration model: order of bursts for this round.
  task automatic plan();
    bit mw[N];
    bit mr[N];
    bit first;
    int w;
    int idx;
    ev_t e;
    first = 1;
    for (int i = 0; i < N; i++) begin
      mw[i] = r_wr[i];
      mr[i] = r_rd[i];
    end
    forever begin
      w = -1;
      for (int k = 0; k < N; k++) begin
`ifdef HS_SPI_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (ptr_m + k) % N;
`endif
        if (w < 0 && (mw[idx] || mr[idx]) &&
            !(first && r_late[idx])) w = idx;
      end
      if (w < 0 && first) begin
        first = 0;
        continue;
      end
      if (w < 0) break;
      e.who = w; e.addr = r_addr[w]; e.bc = r_bc[w];
      if (mw[w]) begin
        mw[w] = 0;
        for (int k = 0; k < blen(r_bc[w]); k++) begin
          e.kind = 0; e.data = d_wdat[w][k];
          exp_q.push_back(e);
        end
      end else begin
        mr[w] = 0;
        e.kind = 1; e.data = '0;
        exp_q.push_back(e);
        for (int k = 0; k < blen(r_bc[w]); k++) begin
          e.kind = 2; e.data = rdat(r_addr[w], k);
          exp_q.push_back(e);
        end
      end
`ifndef HS_SPI_ARB_FIXED_PRIO_EN
      ptr_m = (w + 1) % N;
`endif
      first = 0;
    end
  endtask

  task automatic init_round();
    for (int i = 0; i < N; i++) begin
      d_addr[i] = r_addr[i]; d_bc[i] = r_bc[i];
      d_wlen[i] = blen(r_bc[i]); d_rlen[i] = blen(r_bc[i]);
      d_wbeat[i] = 0; d_rgot[i] = 0;
      d_wact[i] = r_wr[i]; d_ract[i] = r_rd[i];
      d_rwait[i] = 0; d_hold[i] = r_late[i];
      for (int k = 0; k < MB; k++)
        d_wdat[i][k] = use_seq ? DW'(k + 1) : $urandom;
    end
    plan();
    apply();
  endtask

  // One clock: requester drivers plus the SPI-master stand-in.
  task automatic step();
    logic [N-1:0]  wacc;
    logic [N-1:0]  racc;
    logic [N-1:0]  rdv;
    logic          swacc;
    logic          sracc;
    logic [AW-1:0] saddr;
    logic [BW-1:0] sbc;
    logic          bsy;
    @(negedge clk);
    wacc  = req_write & ~req_waitrequest;
    racc  = req_read & ~req_write & ~req_waitrequest;
    rdv   = req_readdatavalid;
    swacc = spi_write & ~spi_waitrequest;
    sracc = spi_read & ~spi_waitrequest;
    saddr = spi_address;
    sbc   = spi_burstcount;
    bsy   = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (d_hold[i] && bsy) d_hold[i] = 0;
      if (wacc[i]) begin
        d_wbeat[i]++;
        if (d_wbeat[i] >= d_wlen[i]) d_wact[i] = 0;
      end
      if (racc[i]) d_rwait[i] = 1;
      if (rdv[i]) begin
        d_rgot[i]++;
        if (d_rgot[i] >= d_rlen[i]) begin
          d_ract[i] = 0;
          d_rwait[i] = 0;
        end
      end
    end
    if (s_tail > 0) s_tail--;
    if (swacc) begin
      if (!s_wopen) begin
        s_wrem = blen(sbc) - 1;
        s_wopen = (s_wrem != 0);
      end else begin
        s_wrem--;
        s_wopen = (s_wrem != 0);
      end
      if (!s_wopen) s_tail = $urandom_range(0, 3);
    end
    if (sracc) begin
      for (int k = 0; k < blen(sbc); k++)
        s_rdq.push_back(rdat(saddr, k));
    end
    spi_readdatavalid = 1'b0;
    if (s_rdq.size() > 0) begin
      if ($urandom_range(0, 3) != 0) begin
        spi_readdatavalid = 1'b1;
        spi_readdata = s_rdq.pop_front();
        if (s_rdq.size() == 0) s_tail = $urandom_range(1, 4);
      end
    end else if ($urandom_range(0, 7) == 0) begin
      spi_readdatavalid = 1'b1;
      spi_readdata = $urandom;
    end
    spi_waitrequest = ($urandom_range(0, 2) == 0);
    spi_idle = !s_wopen && (s_rdq.size() == 0) &&
               (s_tail == 0) && !spi_readdatavalid;
    apply();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++)
      if (d_wact[i] || d_ract[i] || d_hold[i]) return 0;
    return 1;
  endfunction

  task automatic run_round();
    int guard;
    init_round();
    guard = 0;
    do begin
      step();
      guard++;
    end while ((!all_done() || busy) && guard < 4000);
    chk("round_timeout", 64'(guard < 4000), 1);
    repeat (3) step();
    chk("round_drain", 64'(exp_q.size()), 0);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_rw"}, {spi_read, spi_write}, 0);
    chk({tag, "_wait"}, req_waitrequest, {N{1'b1}});
    chk({tag, "_rdv"}, req_readdatavalid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 0);
  endtask

  // Monitor: pops the scoreboard on every DUT-side event.
  initial begin
    ev_t          e;
    bit           pb;
    bit           pidle;
    logic [N-1:0] ppend;
    logic [N-1:0] m;
    int           kind;
    int           nlow;
    pb = 0; pidle = 0; ppend = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst) begin
        pb = 0; pidle = 0; ppend = '0;
      end else begin
        kind = -1;
        if (spi_write && !spi_waitrequest) kind = 0;
        else if (spi_read && !spi_waitrequest) kind = 1;
        else if (|req_readdatavalid) kind = 2;
        if (kind >= 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", 64'(kind), 64'hFF);
          end else begin
            e = exp_q.pop_front();
            chk("ev_kind", 64'(kind), 64'(e.kind));
            if (kind == e.kind && kind == 0)
              chk("wr_beat",
                  {owner, spi_address, spi_writedata, spi_burstcount},
                  {OW'(e.who), e.addr, e.data, e.bc});
            if (kind == e.kind && kind == 1)
              chk("rd_cmd", {owner, spi_address, spi_burstcount},
                  {OW'(e.who), e.addr, e.bc});
            if (kind == e.kind && kind == 2) begin
              m = '0;
              m[e.who] = 1'b1;
              chk("rd_data", {req_readdatavalid, req_readdata},
                  {m, e.data});
            end
          end
        end
        nlow = $countones(~req_waitrequest);
        chk("wait_mask",
            64'((nlow == 0) ||
                (busy && nlow == 1 && !req_waitrequest[owner])), 1);
        if (pb && !busy) chk("release_idle", 64'(pidle), 1);
        if (!pb && ppend != '0) chk("grant_latency", 64'(busy), 1);
        pb = busy;
        pidle = spi_idle;
        ppend = req_read | req_write;
      end
    end
  end

  initial begin
    int guard;
    int op;
    bit any;
    rst = 1'b0;
    clear_all();
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Single write burst of 4 with data 1..4.
    clear_all();
    r_wr[0] = 1; r_addr[0] = 10'h040; r_bc[0] = 4;
    use_seq = 1;
    run_round();
    use_seq = 0;

    // Three simultaneous single-beat reads.
    clear_all();
    for (int i = 0; i < N; i++) begin
      r_rd[i] = 1; r_addr[i] = AW'(16 * i + 3); r_bc[i] = 1;
    end
    run_round();

    // Requester 1 write burst 8, requester 0 joins while it runs.
    clear_all();
    r_wr[1] = 1; r_addr[1] = 10'h155; r_bc[1] = 8;
    r_rd[0] = 1; r_addr[0] = 10'h0AA; r_bc[0] = 2; r_late[0] = 1;
    run_round();

    // Read and write asserted together, plus a competing read.
    clear_all();
    r_wr[2] = 1; r_rd[2] = 1; r_addr[2] = 10'h2F0; r_bc[2] = 2;
    r_rd[0] = 1; r_addr[0] = 10'h011; r_bc[0] = 1;
    run_round();

    // Burstcount 0 is one beat.
    clear_all();
    r_wr[0] = 1; r_addr[0] = 10'h321; r_bc[0] = 0;
    r_rd[1] = 1; r_addr[1] = 10'h123; r_bc[1] = 0;
    run_round();

    // Maximum-length burst.
    clear_all();
    r_wr[1] = 1; r_addr[1] = 10'h3FF; r_bc[1] = BW'(MB);
    run_round();

    // Requesters 0 and 2 contending repeatedly.
    for (int n = 0; n < 4; n++) begin
      clear_all();
      r_rd[0] = 1; r_addr[0] = AW'(n); r_bc[0] = 1;
      r_rd[2] = 1; r_addr[2] = AW'(n + 8); r_bc[2] = 1;
      run_round();
    end

    // Reset in the middle of an 8-beat read.
    clear_all();
    r_rd[2] = 1; r_addr[2] = 10'h1C4; r_bc[2] = 8;
    init_round();
    guard = 0;
    while (d_rgot[2] < 3 && guard < 2000) begin
      step();
      guard++;
    end
    chk("mid_read_beats", 64'(d_rgot[2]), 3);
    chk("mid_read_busy", busy, 1);
    #2;
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk_reset("async_reset");
    exp_q.delete();
    clear_all();
    ptr_m = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;
    clear_all();
    r_rd[1] = 1; r_addr[1] = 10'h0F0; r_bc[1] = 1;
    run_round();

    // Randomized rounds.
    for (int n = 0; n < 30; n++) begin
      clear_all();
      any = 0;
      for (int i = 0; i < N; i++) begin
        op = $urandom_range(0, 3);
        r_rd[i] = op[0];
        r_wr[i] = op[1];
        r_addr[i] = AW'($urandom);
        r_bc[i] = BW'($urandom_range(0, 6));
        if (op != 0) any = 1;
      end
      if (!any) r_rd[0] = 1;
      run_round();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hs_spi_avmm_arbiter.md
Name: hs_spi_avmm_arbiter

Overview:
- Shares one hs_spi_master_avmm_m AVMM slave port between N AVMM requesters, e.g. a CPU bridge, a DMA engine and a housekeeping poller.
- Uses round-robin arbitration and locks the grant for a whole burst.
- Releases the grant only after the SPI master has reported idle again.
- Sits directly in front of the SPI master and routes its write beats, read command and read data.

Parameters:
- N, 3, number of requesters (2..8).
- AW, 10, byte address width.
- DW, 32, data width.
- MAX_BURST, 256, maximum burst length; BW = $clog2(MAX_BURST)+1 is the burstcount width.

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset; asynchronous, active-low.
- req_address  in  N*AW  requester i address at [i*AW +: AW].
- req_read  in  N  read request, one bit per requester.
- req_write  in  N  write request, one bit per requester.
- req_writedata  in  N*DW  write data, requester i at [i*DW +: DW].
- req_burstcount  in  N*BW  burst length, requester i at [i*BW +: BW].
- req_waitrequest  out  N  waitrequest per requester.
- req_readdata  out  DW  read data, broadcast to all requesters.
- req_readdatavalid  out  N  read data valid per requester.
- spi_address  out  AW  address to SPI master.
- spi_read  out  1  read to SPI master.
- spi_write  out  1  write to SPI master.
- spi_writedata  out  DW  write data to SPI master.
- spi_burstcount  out  BW  burst length to SPI master.
- spi_waitrequest  in  1  waitrequest from SPI master.
- spi_readdata  in  DW  read data from SPI master.
- spi_readdatavalid  in  1  read data valid from SPI master.
- spi_idle  in  1  idle output of the SPI master.
- owner  out  $clog2(N)  index of the current grant holder (debug).
- busy  out  1  high in any state other than ARB.

Behaviour:
- Reset (rst low, asynchronous):
  - state ARB, owner 0, round-robin pointer 0, beat counter 0.
  - spi_read and spi_write 0; req_waitrequest all 1; req_readdatavalid all 0; busy 0.
- States are ARB, XFER_WR, XFER_RD_CMD, XFER_RD_DATA and RELEASE.
- ARB:
  - pending[i] = req_read[i] | req_write[i].
  - The winner is the first pending index at or after the pointer, wrapping modulo N.
  - If the winner has write asserted, go to XFER_WR; otherwise go to XFER_RD_CMD.
  - Register the winner's burstcount into len; burstcount 0 is treated as 1.
  - Forwarding to the SPI master starts the next cycle, so grant latency is 1 clk.
  - Nothing is forwarded in ARB.
- Muxing in all XFER_* states:
  - The owner's address, writedata and burstcount are driven combinationally onto spi_*.
  - req_waitrequest[owner] = spi_waitrequest; every other requester sees waitrequest 1.
- XFER_WR:
  - spi_write = req_write[owner].
  - Each accepted beat (write & ~spi_waitrequest) increments cnt.
  - The beat with cnt == len-1 moves to RELEASE.
- XFER_RD_CMD:
  - spi_read = req_read[owner].
  - On acceptance (read & ~spi_waitrequest), go to XFER_RD_DATA.
- XFER_RD_DATA:
  - spi_read = 0.
  - req_readdatavalid[owner] = spi_readdatavalid; req_readdata = spi_readdata.
  - cnt increments on each valid beat; the beat with cnt == len-1 moves to RELEASE.
- RELEASE:
  - spi_read and spi_write are 0; all waitrequest is 1.
  - Stay until spi_idle == 1, then set pointer = owner+1 (mod N), clear cnt and go to ARB.
  - Minimum 1 cycle, so a deasserting idle is never sampled stale.
- Boundary conditions:
  - Owner asserts read and write together: write wins; the read stays pending for a later grant.
  - spi_readdatavalid outside XFER_RD_DATA is dropped; it is never routed to any requester.
  - Requests from non-owners keep waitrequest 1 and stay pending; requests are never lost.
  - Starvation is bounded: each requester waits at most N-1 bursts.
  - Reset mid-burst aborts the transfer immediately; the SPI master is reset on the same reset net.
- The cnt width is BW; a burst of MAX_BURST completes without overflow.

Optional Feature:
- Macro HS_SPI_ARB_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority (lowest index wins) and the pointer is not updated.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Single requester 0, write burst 4 at 0x040, data 1..4 -> spi_write for exactly 4 accepted beats; busy falls only after spi_idle is high; owner = 0.
- Requesters 0, 1 and 2 each post a read of burst 1 at the same cycle -> grants in order 0, 1, 2; each gets exactly one readdatavalid; the other two valid bits stay 0.
- Requester 1 holds a write burst 8 while requester 0 requests -> requester 0 sees waitrequest 1 for the whole burst and is granted next, 1 cycle after spi_idle rises.
- Owner asserts read and write simultaneously with burst 2 -> write performed first; read granted in a later arbitration.
- rst driven low during XFER_RD_DATA after 3 of 8 beats -> outputs take reset values asynchronously; after release a new burst-1 read completes normally.
- Build with HS_SPI_ARB_FIXED_PRIO_EN, requesters 0 and 2 continuously requesting -> requester 0 always wins; without the macro they alternate.
